ball_spawn_loader: RTL
======================

// Module: ball_spawn_loader
// PURPOSE
// - Central loader that writes initial state (X, Y, Xspeed, Yspeed) into NUM_BALLS ball slots over one shared load bus.
// - Supports two sources:
//   - Level start: a per-slot unit table is loaded into every enabled slot.
//   - Ball split: queued split requests each spawn two children, placed into free slots.
// - Sits between the level/unit tables and the ball objects; a ball latches the bus in the cycle its load_en bit pulses.
// PARAMETERS
// NUM_BALLS    4         number of ball slots (2..16)
// COORD_W      11        coordinate width, unsigned
// SPEED_W      16        speed width, signed two's complement
// QDEPTH       4         split request queue depth, power of 2
// SPLIT_YSPEED -16'sd200 Y speed given to both split children (upward kick)
// PORTS
// clk          in   1                  system clock
// resetN       in   1                  asynchronous, active-low reset
// level_start  in   1                  1-cycle pulse: reload all slots from the unit table
// unit_x       in   NUM_BALLS*COORD_W  slot i at [i*COORD_W +: COORD_W]; same packing for unit_y
// unit_y       in   NUM_BALLS*COORD_W
// unit_xspeed  in   NUM_BALLS*SPEED_W  slot i at [i*SPEED_W +: SPEED_W]; same packing for unit_yspeed
// unit_yspeed  in   NUM_BALLS*SPEED_W
// unit_en      in   NUM_BALLS          slot present in this level
// slot_alive   in   NUM_BALLS          slot currently holds a live ball
// split_valid  in   1                  split request; payload below
// split_ready  out  1                  = queue not full (combinational)
// split_x      in   COORD_W            split payload
// split_y      in   COORD_W            split payload
// split_xspeed in   SPEED_W            split payload
// load_en      out  NUM_BALLS          one-hot or zero, 1-cycle pulse
// load_x       out  COORD_W            load bus, valid while load_en != 0; same for load_y/xspeed/yspeed
// load_y       out  COORD_W
// load_xspeed  out  SPEED_W
// load_yspeed  out  SPEED_W
// busy         out  1                  state != IDLE or queue non-empty
// drop_cnt     out  8                  children discarded for lack of a free slot; saturates at 255
// BEHAVIOUR
// - Reset (resetN=0, async): state=IDLE, queue empty, claimed=0.
//   - Outputs: load_en=0, load bus=0, drop_cnt=0, busy=0, split_ready=1.
// - All outputs except split_ready and busy are registered. Load bus and load_en change in the same cycle.
// - FSM states: IDLE, INIT, SPLIT_A, SPLIT_B.
// - level_start has top priority, from any state:
//   - Next state is INIT with idx=0; the queue is flushed, claimed=0, and any split in progress is aborted.
//   - A split_valid in the same cycle as level_start is dropped; it is not counted in drop_cnt.
// - INIT: one slot per cycle.
//   - If unit_en[idx]: load_en[idx]=1 with the unit table values for slot idx.
//   - After idx=NUM_BALLS-1, go to IDLE. INIT always takes NUM_BALLS cycles.
// - IDLE: if the queue is non-empty, pop the head into a register and go to SPLIT_A; otherwise clear claimed.
// - Free-slot search: free = ~slot_alive & ~claimed; pick the lowest index.
//   - claimed covers slots loaded within the last two cycles, since slot_alive lags a load by one cycle.
// - SPLIT_A: child A gets x, y, xspeed=+|xspeed|, yspeed=SPLIT_YSPEED. The chosen slot's claimed bit is set.
// - SPLIT_B: child B is identical to A except xspeed=-|xspeed|; it must use a slot different from A.
// - No free slot in SPLIT_A or SPLIT_B: load_en=0 and drop_cnt increments.
// - Sign handling: |xspeed| saturates, so -32768 becomes +32767. Child B of that case gets -32767.
// - Latency: a split pushed at cycle t into an empty queue while IDLE pulses child A at t+2 and child B at t+3.
// - Queue accepts a push and a pop in the same cycle. When full, split_ready=0 and split_valid is ignored.
// STRUCTURE
// - Package ball_pkg:
//   - constants COORD_W and SPEED_W;
//   - typedef ball_state_t (struct packed: x, y, xspeed, yspeed);
//   - enum spawn_state_t;
//   - function first_free(mask) returning index and found flag;
//   - function abs_sat().
// - Sub-module split_fifo: synchronous FIFO of QDEPTH entries of {x, y, xspeed}, with flush, full and empty.
// TESTING
// - Reset mid-INIT: load_en=0 and drop_cnt=0 immediately; after release, busy=0 and split_ready=1.
// - level_start with unit_en=4'b0101: load_en=0001 then 0000, 0100, 0000 over 4 cycles; values match the table.
// - Split (x=300, y=200, xs=-50), alive=0001: A on slot1 with xs=+50, ys=-200 at t+2; B on slot2 with xs=-50 at t+3.
// - Split with alive=1110: A loads slot0; B finds no free slot (slot0 claimed), so drop_cnt=1.
// - Push 5 splits back-to-back (QDEPTH=4) while busy: split_ready=0 on the 5th; 4 pairs are loaded in order.
// - xs=-32768: children get +32767 and -32767. level_start during SPLIT_A: B is never emitted and the queue is empty.

Source files
------------

// File: rtl/ball_pkg.sv
// Shared types and helpers for the ball spawn loader: slot search and
// saturating magnitude used when splitting a ball into two children.
package ball_pkg;

  localparam int unsigned COORD_W   = 11;
  localparam int unsigned SPEED_W   = 16;
  localparam int unsigned MAX_BALLS = 16;

  typedef struct packed {
    logic [COORD_W-1:0]        x;
    logic [COORD_W-1:0]        y;
    logic signed [SPEED_W-1:0] xspeed;
    logic signed [SPEED_W-1:0] yspeed;
  } ball_state_t;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    SPLIT_A,
    SPLIT_B
  } spawn_state_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } free_slot_t;

  function automatic free_slot_t first_free(input logic [MAX_BALLS-1:0] mask);
    free_slot_t r;
    r = '0;
    for (int unsigned i = 0; i < MAX_BALLS; i++) begin
      if (mask[i] && !r.found) begin
        r.found = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

  // The most negative speed has no positive counterpart, so it clamps to max.
  function automatic logic signed [SPEED_W-1:0] abs_sat(input logic signed [SPEED_W-1:0] v);
    if (v == {1'b1, {(SPEED_W-1){1'b0}}})
      return {1'b0, {(SPEED_W-1){1'b1}}};
    return v[SPEED_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/split_fifo.sv
// Split request queue: synchronous FIFO of {x, y, xspeed} with flush.
module split_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 38
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !flush)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ball_spawn_loader.sv
// Central loader driving the shared ball load bus from the level unit table
// (level start) or from queued split requests (two children per request).
module ball_spawn_loader
  import ball_pkg::*;
#(
  parameter int unsigned NUM_BALLS = 4,
  parameter int unsigned COORD_W   = 11,
  parameter int unsigned SPEED_W   = 16,
  parameter int unsigned QDEPTH    = 4,
  parameter logic signed [SPEED_W-1:0] SPLIT_YSPEED = -16'sd200
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           level_start,
  input  logic [NUM_BALLS*COORD_W-1:0]   unit_x,
  input  logic [NUM_BALLS*COORD_W-1:0]   unit_y,
  input  logic [NUM_BALLS*SPEED_W-1:0]   unit_xspeed,
  input  logic [NUM_BALLS*SPEED_W-1:0]   unit_yspeed,
  input  logic [NUM_BALLS-1:0]           unit_en,
  input  logic [NUM_BALLS-1:0]           slot_alive,
  input  logic                           split_valid,
  output logic                           split_ready,
  input  logic [COORD_W-1:0]             split_x,
  input  logic [COORD_W-1:0]             split_y,
  input  logic signed [SPEED_W-1:0]      split_xspeed,
  output logic [NUM_BALLS-1:0]           load_en,
  output logic [COORD_W-1:0]             load_x,
  output logic [COORD_W-1:0]             load_y,
  output logic signed [SPEED_W-1:0]      load_xspeed,
  output logic signed [SPEED_W-1:0]      load_yspeed,
  output logic                           busy,
  output logic [7:0]                     drop_cnt
);

  localparam int unsigned IW = $clog2(NUM_BALLS);
  localparam int unsigned QW = 2*COORD_W + SPEED_W;

  spawn_state_t              state;
  logic [IW-1:0]             idx;
  logic [NUM_BALLS-1:0]      claimed, free_mask, slot_hot, init_hot;
  logic [COORD_W-1:0]        hx, hy, q_x, q_y, cx, cy;
  logic signed [SPEED_W-1:0] habs, q_xs, cxs;
  logic [QW-1:0]             q_dout;
  logic                      q_full, q_empty, q_push, q_pop, spawn;
  free_slot_t                pick;

  assign q_push = split_valid && !level_start;
  assign q_pop  = (state == IDLE) && !q_empty && !level_start;

  split_fifo #(
    .DEPTH(QDEPTH),
    .WIDTH(QW)
  ) u_fifo (
    .clk   (clk),
    .resetN(resetN),
    .flush (level_start),
    .push  (q_push),
    .pop   (q_pop),
    .din   ({split_x, split_y, split_xspeed}),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty)
  );

  assign {q_x, q_y, q_xs} = q_dout;
  assign split_ready = !q_full;
  assign busy        = (state != IDLE) || !q_empty;

  // Child A is emitted straight from the queue head while popping it, so it
  // reaches the bus one cycle after the pop decision; child B follows from the
  // held copy, which keeps the push-to-A latency at two cycles.
  always_comb begin
    free_mask = ~slot_alive & ~claimed;
    pick      = first_free(MAX_BALLS'(free_mask));
    slot_hot  = pick.found ? (NUM_BALLS'(1) << pick.idx) : '0;
    init_hot  = NUM_BALLS'(1) << idx;
    spawn     = ((state == IDLE) && !q_empty) || (state == SPLIT_A);
    if (state == IDLE) begin
      cx  = q_x;
      cy  = q_y;
      cxs = abs_sat(q_xs);
    end else begin
      cx  = hx;
      cy  = hy;
      cxs = -habs;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE;
      idx         <= '0;
      claimed     <= '0;
      hx          <= '0;
      hy          <= '0;
      habs        <= '0;
      load_en     <= '0;
      load_x      <= '0;
      load_y      <= '0;
      load_xspeed <= '0;
      load_yspeed <= '0;
      drop_cnt    <= '0;
    end else begin
      load_en     <= '0;
      load_x      <= '0;
      load_y      <= '0;
      load_xspeed <= '0;
      load_yspeed <= '0;
      if (level_start) begin
        state   <= INIT;
        idx     <= '0;
        claimed <= '0;
      end else begin
        case (state)
          INIT: begin
            if (unit_en[idx]) begin
              load_en     <= init_hot;
              load_x      <= unit_x[idx*COORD_W +: COORD_W];
              load_y      <= unit_y[idx*COORD_W +: COORD_W];
              load_xspeed <= unit_xspeed[idx*SPEED_W +: SPEED_W];
              load_yspeed <= unit_yspeed[idx*SPEED_W +: SPEED_W];
            end
            if (idx == IW'(NUM_BALLS-1))
              state <= IDLE;
            idx <= idx + 1'b1;
          end
          IDLE: begin
            if (!q_empty) begin
              hx    <= q_x;
              hy    <= q_y;
              habs  <= cxs;
              state <= SPLIT_A;
            end else begin
              claimed <= '0;
            end
          end
          SPLIT_A: state <= SPLIT_B;
          SPLIT_B: state <= IDLE;
          default: state <= IDLE;
        endcase

        if (spawn) begin
          if (pick.found) begin
            load_en     <= slot_hot;
            load_x      <= cx;
            load_y      <= cy;
            load_xspeed <= cxs;
            load_yspeed <= SPLIT_YSPEED;
            claimed     <= claimed | slot_hot;
          end else if (drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule
